// File: rtl/cmos_sync_decoder_param.sv
// Embedded-sync decoder: finds ones/zero/zero/code sequences in a sensor word stream,
// tracks frame/line state, strips sync words and counts pixels and lines.
module cmos_sync_decoder_param #(
    parameter int unsigned DW = 12,
    parameter int unsigned CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_dvld,
    input  logic [DW-1:0] i_data,
    input  logic [DW-1:0] i_code_fs,
    input  logic [DW-1:0] i_code_fe,
    input  logic [DW-1:0] i_code_ls,
    input  logic [DW-1:0] i_code_le,
    input  logic [CW-1:0] i_exp_pix,
    output logic          o_fvld,
    output logic          o_lvld,
    output logic          o_dvld,
    output logic [DW-1:0] o_data,
    output logic [CW-1:0] o_pix_cnt,
    output logic [CW-1:0] o_line_cnt,
    output logic          o_err_len,
    output logic          o_err_seq
);

    localparam logic [DW-1:0] ONES    = {DW{1'b1}};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        LINE  = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] d0_q, d1_q, d2_q, d3_q;
    logic [3:0]    tag_q;
    logic          prev_t3_q;
    logic          fvld_q, lvld_q, dvld_q, err_len_q, err_seq_q;
    logic [DW-1:0] data_q;
    logic [CW-1:0] pix_cnt_q, line_cnt_q;

    logic pre_ok, hit;
    logic det_fs, det_fe, det_ls, det_le, det_any;
    logic clr_pre, tag_in;

    // Code detection on the accepted word; FS > FE > LS > LE when codes alias
    assign pre_ok  = (d2_q == ONES) && (d1_q == '0) && (d0_q == '0);
    assign hit     = i_dvld && pre_ok;
    assign det_fs  = hit && (i_data == i_code_fs);
    assign det_fe  = hit && (i_data == i_code_fe) && !det_fs;
    assign det_ls  = hit && (i_data == i_code_ls) && !det_fs && !det_fe;
    assign det_le  = hit && (i_data == i_code_le) && !det_fs && !det_fe && !det_ls;
    assign det_any = det_fs || det_fe || det_ls || det_le;

    // Any line-terminating code retroactively untags its three preamble words
    assign clr_pre = (state_q == LINE) && (det_le || det_fe || det_fs);
    assign tag_in  = (state_q == LINE) && !det_any;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            d0_q       <= '0;
            d1_q       <= '0;
            d2_q       <= '0;
            d3_q       <= '0;
            tag_q      <= '0;
            prev_t3_q  <= 1'b0;
            fvld_q     <= 1'b0;
            lvld_q     <= 1'b0;
            dvld_q     <= 1'b0;
            data_q     <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            err_len_q  <= 1'b0;
            err_seq_q  <= 1'b0;
        end else begin
            dvld_q    <= 1'b0;
            err_len_q <= 1'b0;
            err_seq_q <= 1'b0;
            if (i_dvld) begin
                d0_q      <= i_data;
                d1_q      <= d0_q;
                d2_q      <= d1_q;
                d3_q      <= d2_q;
                tag_q     <= {tag_q[2:0] & {3{~clr_pre}}, tag_in};
                data_q    <= d3_q;
                dvld_q    <= tag_q[3];
                prev_t3_q <= tag_q[3];

                // Output-side line tracking: a tagged word extends the line, the first untagged one closes it
                if (tag_q[3]) begin
                    lvld_q <= 1'b1;
                    if (!prev_t3_q) begin
                        pix_cnt_q <= CW'(1);
                    end else if (pix_cnt_q != CNT_MAX) begin
                        pix_cnt_q <= pix_cnt_q + CW'(1);
                    end
                end else if (prev_t3_q) begin
                    lvld_q <= 1'b0;
                    if (line_cnt_q != CNT_MAX) begin
                        line_cnt_q <= line_cnt_q + CW'(1);
                    end
                    if ((i_exp_pix != '0) && (pix_cnt_q != i_exp_pix)) begin
                        err_len_q <= 1'b1;
                    end
                end

                // Frame/line state machine; a frame (re)start overrides the line-close count
                case (state_q)
                    IDLE: begin
                        if (det_fs) begin
                            state_q    <= FRAME;
                            fvld_q     <= 1'b1;
                            line_cnt_q <= '0;
                        end else if (det_any) begin
                            err_seq_q <= 1'b1;
                        end
                    end
                    FRAME: begin
                        if (det_fs) begin
                            err_seq_q  <= 1'b1;
                            line_cnt_q <= '0;
                        end else if (det_fe) begin
                            state_q <= IDLE;
                            fvld_q  <= 1'b0;
                        end else if (det_ls) begin
                            state_q <= LINE;
                        end else if (det_le) begin
                            err_seq_q <= 1'b1;
                        end
                    end
                    LINE: begin
                        if (det_fs) begin
                            err_seq_q  <= 1'b1;
                            state_q    <= FRAME;
                            line_cnt_q <= '0;
                        end else if (det_fe) begin
                            err_seq_q <= 1'b1;
                            state_q   <= IDLE;
                            fvld_q    <= 1'b0;
                        end else if (det_ls) begin
                            err_seq_q <= 1'b1;
                        end else if (det_le) begin
                            state_q <= FRAME;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        fvld_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_fvld     = fvld_q;
    assign o_lvld     = lvld_q;
    assign o_dvld     = dvld_q;
    assign o_data     = data_q;
    assign o_pix_cnt  = pix_cnt_q;
    assign o_line_cnt = line_cnt_q;
    assign o_err_len  = err_len_q;
    assign o_err_seq  = err_seq_q;

endmodule

// File: doc/cmos_sync_decoder_param.md
Name: cmos_sync_decoder_param

Overview:
- Parametrised successor to the fixed 12-bit embedded-sync decoder.
- Decodes a sensor word stream carrying embedded 4-word sync codes: preamble all-ones, zero, zero, then a code word.
- Generates frame, line and data valid signals and strips all sync words from the pixel output.
- Adds run-time programmable codes, a frame/line state machine, pixel/line counters, and line-length and sequence error flags.
- Sits between the deserializer word aligner and the pixel pipeline.

Parameters:
DW, 12, pixel/sync word width; preamble = {DW{1'b1}}, {DW{1'b0}}, {DW{1'b0}}.
CW, 16, width of pixel and line counters.

Ports:
i_clk  in  1  pixel-word clock.
i_rstn  in  1  asynchronous, active-low reset.
i_dvld  in  1  input word valid; all pipeline and detection logic advances only when high.
i_data  in  DW  input word.
i_code_fs  in  DW  frame-start code.
i_code_fe  in  DW  frame-end code.
i_code_ls  in  DW  line-start code.
i_code_le  in  DW  line-end code.
i_exp_pix  in  CW  expected pixels per line; 0 disables the length check.
o_fvld  out  1  frame valid.
o_lvld  out  1  line valid (aligned to output pixels).
o_dvld  out  1  output pixel strobe.
o_data  out  DW  output pixel.
o_pix_cnt  out  CW  pixels output so far in the current line.
o_line_cnt  out  CW  lines completed in the current frame.
o_err_len  out  1  one-cycle pulse: line length differed from i_exp_pix.
o_err_seq  out  1  one-cycle pulse: illegal sync sequence.

Behaviour:
- Reset: all outputs 0, state IDLE, delay line and tags cleared. Reset mid-line aborts immediately; no error pulse.
- Delay line: 4 stages d0..d3 (DW bits each), each with a 1-bit tag t0..t3. Shifts on i_dvld.
  - Incoming tag = 1 when state==LINE and the word is not a detected code.
- Detection is evaluated combinationally on an accepted word: d2==ones && d1==0 && d0==0 && i_data==code. The resulting state change registers on that same edge.
  - Priority if codes are programmed equal: FS > FE > LS > LE.
- FSM:
  - IDLE: FS -> FRAME (o_fvld<=1, o_line_cnt<=0). Any LS/LE/FE -> o_err_seq, stay IDLE.
  - FRAME: LS -> LINE. FE -> IDLE (o_fvld<=0). LE or FS -> o_err_seq; FS additionally restarts the frame (o_line_cnt<=0).
  - LINE: LE -> FRAME, and the tags of the three preamble words in t0..t2 are cleared on the same edge. FE or FS -> o_err_seq, then:
    - FE -> IDLE;
    - FS -> FRAME;
    - in both cases preamble tags are cleared and the line is closed.
  - LS in LINE -> o_err_seq, stay LINE.
- Output: on each i_dvld, o_data<=d3 and o_dvld<=t3; o_dvld is 0 on cycles without i_dvld.
  - Latency: a pixel accepted on edge n is output after 4 further accepted words, plus 1 clk register.
  - The pipeline drains only on subsequent accepted words; blanking words are expected to follow.
- o_lvld: set with the first o_dvld of a line. Cleared on the accepted word whose t3==0 follows a t3==1 word (line close).
- o_pix_cnt: reset to 0 on the line-start output. Increments per o_dvld and saturates at all-ones.
- Line close:
  - o_line_cnt increments, saturating.
  - If i_exp_pix!=0 and final o_pix_cnt!=i_exp_pix, pulse o_err_len for 1 clk.
  - Zero-pixel lines (LS immediately followed by LE preamble) do not assert o_lvld, do not count, and produce no o_err_len.
- o_fvld drops on the FE edge, even if output pixels of the last line are still draining; those pixels are still emitted with o_lvld high.
- Codes are sampled each word. Changing a code mid-frame takes effect on the next word.

Test Plan:
- DW=12, codes AB0/B60/800/9D0, i_exp_pix=4. Frame: FS, 2 lines of 4 pixels (0x101..0x104), FE, blanking.
  - Required: o_dvld 8 pulses, data exact, no sync words output.
  - Required: o_line_cnt=2 at FE, o_fvld 1->0, no errors.
- Line with 3 pixels and i_exp_pix=4: o_err_len single pulse at line close, o_line_cnt still increments. Repeat with i_exp_pix=0: no pulse.
- LS before FS: o_err_seq pulse, o_dvld stays 0. FE in mid-line: o_err_seq, state IDLE, line truncated, preamble not output.
- i_dvld toggling 1/0 every cycle: identical output data sequence, o_dvld only on i_dvld cycles.
- DW=10 instance with programmed codes 0x2AC/0x2D8/0x200/0x274: correct decode. Pixel value equal to a code without preamble: treated as data.
- Assert i_rstn low mid-line: all outputs 0 asynchronously. After release, ignore words until the next FS.
